// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt controller.
package irq_pkg;

  localparam int NSRC = 4;
  localparam logic [11:0] IRQ_MASK_ADDR = 12'h1F0;
  localparam logic [11:0] IRQ_EOI_ADDR  = 12'h1F8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled pending sources.
module irq_prio_enc #(
  parameter int NSRC = irq_pkg::NSRC
) (
  input  logic [NSRC-1:0] vector,
  output logic [1:0]      index,
  output logic            valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (vector[i]) begin
        index = 2'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-captured pending flags, a memory-mapped mask/EOI
// snooped off the data-memory bus, and a single-level request/service FSM.
//
// state   | meaning
// IDLE    | no interrupt in flight; waiting for an enabled pending source
// REQ     | ExtIRQ raised for irq_id; waiting for ExtIAck
// SERVICE | handler running for irq_id; waiting for an EOI write
module irq_controller #(
  parameter int N    = 64,
  parameter int NSRC = irq_pkg::NSRC
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [N-1:0]    DM_addr,
  input  logic [N-1:0]    DM_writeData,
  input  logic            DM_writeEnable,
  input  logic            ExtIAck,
  output logic            ExtIRQ,
  output logic [1:0]      irq_id,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask
);

  import irq_pkg::*;

  irq_state_e      state_q, state_d;
  logic [NSRC-1:0] src_q, pending_q, mask_q;
  logic [NSRC-1:0] rise, active, ack_clr;
  logic [1:0]      irq_id_q, enc_index;
  logic            enc_valid, armed_q, ext_irq_q;
  logic            mask_wr, eoi_wr;
  logic            unused_wdata;

  assign unused_wdata = ^DM_writeData[N-1:NSRC];

  assign mask_wr = DM_writeEnable && (DM_addr == N'(IRQ_MASK_ADDR));
  assign eoi_wr  = DM_writeEnable && (DM_addr == N'(IRQ_EOI_ADDR));

  // armed_q stays low for the first cycle after reset so that a line already
  // high at release is taken as the baseline rather than a new edge.
  assign rise   = armed_q ? (irq_src & ~src_q) : '0;
  assign active = pending_q & mask_q;

  irq_prio_enc #(.NSRC(NSRC)) u_prio_enc (
    .vector (active),
    .index  (enc_index),
    .valid  (enc_valid)
  );

  always_comb begin
    state_d = state_q;
    ack_clr = '0;
    case (state_q)
      IDLE: begin
        if (enc_valid) state_d = REQ;
      end
      REQ: begin
        if (ExtIAck) begin
          state_d           = SERVICE;
          ack_clr[irq_id_q] = 1'b1;
        end else if (!mask_q[irq_id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eoi_wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      src_q     <= '0;
      armed_q   <= 1'b0;
      pending_q <= '0;
      mask_q    <= '0;
      irq_id_q  <= '0;
      ext_irq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= irq_src;
      armed_q   <= 1'b1;
      // A fresh edge outranks the ack clearing the same bit.
      pending_q <= (pending_q & ~ack_clr) | rise;
      if (mask_wr) mask_q <= DM_writeData[NSRC-1:0];
      if (state_q == IDLE && enc_valid) irq_id_q <= enc_index;
      ext_irq_q <= (state_d == REQ);
    end
  end

  assign ExtIRQ  = ext_irq_q;
  assign irq_id  = irq_id_q;
  assign pending = pending_q;
  assign mask    = mask_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scenario bench for irq_controller: expected {ExtIRQ,irq_id,pending,mask}
// is queued as each cycle is driven and compared against the sampled outputs.
module tb_irq_controller;

  localparam logic [63:0] MA = 64'h1F0;
  localparam logic [63:0] EA = 64'h1F8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq_src = '0;
  logic [63:0] DM_addr = '0;
  logic [63:0] DM_writeData = '0;
  logic        DM_writeEnable = 1'b0;
  logic        ExtIAck = 1'b0;
  logic        ExtIRQ;
  logic [1:0]  irq_id;
  logic [3:0]  pending;
  logic [3:0]  mask;

  typedef struct {
    logic [10:0] v;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] obs_q[$];
  int          tests = 0;
  int          fails = 0;
  exp_t        e;
  logic [10:0] o;

  irq_controller #(.N(64)) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .irq_src        (irq_src),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_writeEnable (DM_writeEnable),
    .ExtIAck        (ExtIAck),
    .ExtIRQ         (ExtIRQ),
    .irq_id         (irq_id),
    .pending        (pending),
    .mask           (mask)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] pk(input logic x, input logic [1:0] id,
                                     input logic [3:0] p, input logic [3:0] m);
    return {x, id, p, m};
  endfunction

  task automatic drive(input logic r, input logic [3:0] s, input logic we,
                       input logic [63:0] a, input logic [63:0] d, input logic ack,
                       input logic [10:0] ev, input string tag);
    exp_t t;
    @(negedge clk);
    reset = r; irq_src = s; DM_writeEnable = we; DM_addr = a;
    DM_writeData = d; ExtIAck = ack;
    t.v = ev; t.tag = tag;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    obs_q.push_back({ExtIRQ, irq_id, pending, mask});
  endtask

  task automatic idle(input logic [3:0] s, input logic ack, input logic [10:0] ev, input string tag);
    drive(1'b0, s, 1'b0, 64'h0, 64'h0, ack, ev, tag);
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [3:0] s,
                    input logic ack, input logic [10:0] ev, input string tag);
    drive(1'b0, s, 1'b1, a, d, ack, ev, tag);
  endtask

  task automatic fresh(input string tag);
    drive(1'b1, 4'h0, 1'b0, 64'h0, 64'h0, 1'b0, pk(0, 0, 4'h0, 4'h0), {tag, "_rst"});
    idle(4'h0, 1'b0, pk(0, 0, 4'h0, 4'h0), {tag, "_arm"});
  endtask

  task automatic test_reset;
    drive(1'b1, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, pk(0, 0, 4'h0, 4'h0), "rst_hold0");
    drive(1'b1, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, pk(0, 0, 4'h0, 4'h0), "rst_hold1");
    idle(4'hF, 1'b0, pk(0, 0, 4'h0, 4'h0), "rst_release_high");
    idle(4'hF, 1'b0, pk(0, 0, 4'h0, 4'h0), "rst_still_high");
    idle(4'h0, 1'b0, pk(0, 0, 4'h0, 4'h0), "rst_drop");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e.v) begin fails++; $display("FAIL %s: got %03h expected %03h", e.tag, o, e.v); end
    end
  endtask

  task automatic test_basic;
    fresh("s1");
    wr(64'h1F4, 64'hF, 4'h0, 1'b0, pk(0, 0, 4'h0, 4'h0), "s1_bad_addr");
    wr(64'h1_0000_01F0, 64'hF, 4'h0, 1'b0, pk(0, 0, 4'h0, 4'h0), "s1_high_addr");
    drive(1'b0, 4'h0, 1'b0, MA, 64'hF, 1'b0, pk(0, 0, 4'h0, 4'h0), "s1_no_we");
    wr(MA, 64'hFFFF_FFF0_0000_000F, 4'h0, 1'b0, pk(0, 0, 4'h0, 4'hF), "s1_mask");
    idle(4'h4, 1'b0, pk(0, 0, 4'h4, 4'hF), "s1_edge");
    idle(4'h0, 1'b0, pk(1, 2, 4'h4, 4'hF), "s1_req");
    idle(4'h0, 1'b0, pk(1, 2, 4'h4, 4'hF), "s1_req_hold");
    idle(4'h0, 1'b1, pk(0, 2, 4'h0, 4'hF), "s1_ack");
    idle(4'h0, 1'b1, pk(0, 2, 4'h0, 4'hF), "s1_ack_in_service");
    wr(MA, 64'hF, 4'h0, 1'b0, pk(0, 2, 4'h0, 4'hF), "s1_mask_wr_in_service");
    wr(EA, 64'h0, 4'h0, 1'b0, pk(0, 2, 4'h0, 4'hF), "s1_eoi");
    wr(EA, 64'h0, 4'h0, 1'b0, pk(0, 2, 4'h0, 4'hF), "s1_eoi_in_idle");
    idle(4'h0, 1'b0, pk(0, 2, 4'h0, 4'hF), "s1_quiet");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e.v) begin fails++; $display("FAIL %s: got %03h expected %03h", e.tag, o, e.v); end
    end
  endtask

  task automatic test_priority;
    fresh("s2");
    wr(MA, 64'hF, 4'h0, 1'b0, pk(0, 0, 4'h0, 4'hF), "s2_mask");
    idle(4'hA, 1'b0, pk(0, 0, 4'hA, 4'hF), "s2_two_edges");
    idle(4'h0, 1'b0, pk(1, 1, 4'hA, 4'hF), "s2_req_low");
    idle(4'h0, 1'b1, pk(0, 1, 4'h8, 4'hF), "s2_ack_low");
    wr(EA, 64'h0, 4'h0, 1'b0, pk(0, 1, 4'h8, 4'hF), "s2_eoi");
    idle(4'h0, 1'b0, pk(1, 3, 4'h8, 4'hF), "s2_req_high");
    idle(4'h0, 1'b1, pk(0, 3, 4'h0, 4'hF), "s2_ack_high");
    wr(EA, 64'h0, 4'h0, 1'b0, pk(0, 3, 4'h0, 4'hF), "s2_eoi2");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e.v) begin fails++; $display("FAIL %s: got %03h expected %03h", e.tag, o, e.v); end
    end
  endtask

  task automatic test_masked;
    fresh("s3");
    idle(4'h1, 1'b0, pk(0, 0, 4'h1, 4'h0), "s3_edge_masked");
    idle(4'h0, 1'b0, pk(0, 0, 4'h1, 4'h0), "s3_no_req0");
    idle(4'h0, 1'b0, pk(0, 0, 4'h1, 4'h0), "s3_no_req1");
    wr(MA, 64'h1, 4'h0, 1'b0, pk(0, 0, 4'h1, 4'h1), "s3_unmask");
    idle(4'h0, 1'b0, pk(1, 0, 4'h1, 4'h1), "s3_req");
    wr(EA, 64'h0, 4'h0, 1'b0, pk(1, 0, 4'h1, 4'h1), "s3_eoi_in_req");
    idle(4'h0, 1'b1, pk(0, 0, 4'h0, 4'h1), "s3_ack");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e.v) begin fails++; $display("FAIL %s: got %03h expected %03h", e.tag, o, e.v); end
    end
  endtask

  // Continues from test_masked: SERVICE on id 0 with mask 0x1.
  task automatic test_no_nesting;
    idle(4'h1, 1'b0, pk(0, 0, 4'h1, 4'h1), "s4_edge_in_service");
    idle(4'h1, 1'b0, pk(0, 0, 4'h1, 4'h1), "s4_held");
    idle(4'h0, 1'b1, pk(0, 0, 4'h1, 4'h1), "s4_stray_ack");
    wr(EA, 64'h0, 4'h0, 1'b0, pk(0, 0, 4'h1, 4'h1), "s4_eoi");
    idle(4'h0, 1'b0, pk(1, 0, 4'h1, 4'h1), "s4_rereq");
    idle(4'h1, 1'b1, pk(0, 0, 4'h1, 4'h1), "s4_set_beats_ack");
    wr(EA, 64'h0, 4'h0, 1'b0, pk(0, 0, 4'h1, 4'h1), "s4_eoi2");
    idle(4'h0, 1'b0, pk(1, 0, 4'h1, 4'h1), "s4_rereq2");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e.v) begin fails++; $display("FAIL %s: got %03h expected %03h", e.tag, o, e.v); end
    end
  endtask

  task automatic test_mask_clear;
    fresh("s5");
    wr(MA, 64'hF, 4'h0, 1'b0, pk(0, 0, 4'h0, 4'hF), "s5_mask");
    idle(4'h2, 1'b0, pk(0, 0, 4'h2, 4'hF), "s5_edge");
    idle(4'h0, 1'b0, pk(1, 1, 4'h2, 4'hF), "s5_req");
    wr(MA, 64'h0, 4'h0, 1'b0, pk(1, 1, 4'h2, 4'h0), "s5_mask_off");
    idle(4'h0, 1'b0, pk(0, 1, 4'h2, 4'h0), "s5_withdraw");
    idle(4'h0, 1'b0, pk(0, 1, 4'h2, 4'h0), "s5_idle_masked");
    wr(MA, 64'hF, 4'h0, 1'b0, pk(0, 1, 4'h2, 4'hF), "s5_remask");
    idle(4'h0, 1'b0, pk(1, 1, 4'h2, 4'hF), "s5_req2");
    wr(MA, 64'h0, 4'h0, 1'b1, pk(0, 1, 4'h0, 4'h0), "s5_ack_with_mask_wr");
    wr(EA, 64'h0, 4'h0, 1'b0, pk(0, 1, 4'h0, 4'h0), "s5_eoi");
    wr(MA, 64'hF, 4'h0, 1'b0, pk(0, 1, 4'h0, 4'hF), "s5_remask2");
    idle(4'h2, 1'b0, pk(0, 1, 4'h2, 4'hF), "s5_edge2");
    idle(4'h0, 1'b0, pk(1, 1, 4'h2, 4'hF), "s5_req3");
    wr(MA, 64'h0, 4'h0, 1'b0, pk(1, 1, 4'h2, 4'h0), "s5_mask_off2");
    idle(4'h0, 1'b1, pk(0, 1, 4'h0, 4'h0), "s5_ack_beats_mask");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e.v) begin fails++; $display("FAIL %s: got %03h expected %03h", e.tag, o, e.v); end
    end
  endtask

  task automatic test_reset_inflight;
    fresh("s6");
    wr(MA, 64'hF, 4'h0, 1'b0, pk(0, 0, 4'h0, 4'hF), "s6_mask");
    idle(4'h4, 1'b0, pk(0, 0, 4'h4, 4'hF), "s6_edge");
    idle(4'h4, 1'b0, pk(1, 2, 4'h4, 4'hF), "s6_req");
    idle(4'h4, 1'b1, pk(0, 2, 4'h0, 4'hF), "s6_service");
    drive(1'b1, 4'h4, 1'b0, 64'h0, 64'h0, 1'b0, pk(0, 0, 4'h0, 4'h0), "s6_rst0");
    drive(1'b1, 4'h4, 1'b0, 64'h0, 64'h0, 1'b0, pk(0, 0, 4'h0, 4'h0), "s6_rst1");
    idle(4'h4, 1'b0, pk(0, 0, 4'h0, 4'h0), "s6_release_high");
    idle(4'h4, 1'b0, pk(0, 0, 4'h0, 4'h0), "s6_no_pending");
    wr(MA, 64'hF, 4'h4, 1'b0, pk(0, 0, 4'h0, 4'hF), "s6_mask2");
    idle(4'h4, 1'b0, pk(0, 0, 4'h0, 4'hF), "s6_no_req");
    idle(4'h0, 1'b0, pk(0, 0, 4'h0, 4'hF), "s6_drop");
    idle(4'h4, 1'b0, pk(0, 0, 4'h4, 4'hF), "s6_new_edge");
    idle(4'h0, 1'b0, pk(1, 2, 4'h4, 4'hF), "s6_req2");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e.v) begin fails++; $display("FAIL %s: got %03h expected %03h", e.tag, o, e.v); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_priority;
    test_masked;
    test_no_nesting;
    test_mask_clear;
    test_reset_inflight;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter N, default 64, data/address width of the snooped data-memory bus.
REQ-002 Parameter NSRC, fixed at 4, number of external interrupt sources.
REQ-003 CLOCK_50  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 irq_src  in  NSRC  raw interrupt request lines from peripherals, synchronous to CLOCK_50.
REQ-006 DM_addr  in  N  processor data-memory address, snooped.
REQ-007 DM_writeData  in  N  processor data-memory write data, snooped.
REQ-008 DM_writeEnable  in  1  processor data-memory write strobe, snooped.
REQ-009 ExtIAck  in  1  processor acknowledge that the exception for ExtIRQ was taken.
REQ-010 ExtIRQ  out  1  interrupt request to the processor.
REQ-011 irq_id  out  2  index of the source being requested or serviced.
REQ-012 pending  out  NSRC  pending flags.
REQ-013 mask  out  NSRC  enable mask; bit=1 means the source is enabled.

Function
REQ-014 The block SHALL register irq_src each cycle and set pending[i] on a 0->1 edge of irq_src[i], regardless of mask.
REQ-015 The block SHALL treat a write with DM_writeEnable=1 and DM_addr=IRQ_MASK_ADDR (0x1F0) as loading mask from DM_writeData[3:0] on the next edge.
REQ-016 The block SHALL treat a write with DM_writeEnable=1 and DM_addr=IRQ_EOI_ADDR (0x1F8) as end-of-interrupt; DM_writeData is ignored.
REQ-017 Snooping SHALL be passive; the data-memory write still completes normally.
REQ-018 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-019 In IDLE, when (pending & mask) is nonzero, the FSM SHALL latch the lowest set index into irq_id and enter REQ on the next edge.
REQ-020 ExtIRQ SHALL be 1 only in REQ and SHALL be a registered output with no combinational path from inputs.
REQ-021 In REQ, ExtIAck=1 SHALL clear pending[irq_id] and move the FSM to SERVICE on the same edge.
REQ-022 In REQ, if mask[irq_id] becomes 0 and ExtIAck=0, the FSM SHALL return to IDLE and leave pending unchanged.
REQ-023 If an ack and a mask-clear of the same source occur in the same cycle, the ack SHALL win.
REQ-024 In SERVICE, ExtIRQ SHALL stay 0 and irq_id SHALL hold; an EOI write SHALL return the FSM to IDLE.
REQ-025 No nesting is supported; new edges only set pending while in SERVICE.
REQ-026 ExtIAck in IDLE or SERVICE, and an EOI write in IDLE or REQ, SHALL be ignored.
REQ-027 If a new rising edge on source i coincides with the ack-clear of pending[i], the set SHALL win.
REQ-028 Request latency SHALL be 2 cycles from the irq_src rising edge to ExtIRQ=1 with the source unmasked: edge->pending, then pending->REQ.
REQ-029 irq_id SHALL be stable throughout REQ and SERVICE.

Reset
REQ-030 While reset=1 on an edge, the block SHALL clear pending, mask, irq_id, ExtIRQ and the edge-detect registers to 0 and set the FSM to IDLE.
REQ-031 A reset asserted during REQ or SERVICE SHALL discard the in-flight interrupt with no ack or EOI required.
REQ-032 A source held high through reset release SHALL NOT create a pending flag.

Structure
REQ-033 A shared package irq_pkg SHALL hold NSRC, IRQ_MASK_ADDR, IRQ_EOI_ADDR and the FSM state enum.
REQ-034 A sub-module irq_prio_enc SHALL implement the combinational lowest-index priority encoder, with inputs vector and outputs index and valid.
REQ-035 The block SHALL instantiate alongside processor_arm at top level, driving ExtIRQ and consuming ExtIAck and the DM_* write signals.

Verification
REQ-036 Scenario 1: after reset, write mask=0xF, pulse irq_src[2] -> ExtIRQ=1 two cycles later with irq_id=2; ExtIAck -> pending[2]=0 and ExtIRQ=0; EOI -> IDLE.
REQ-037 Scenario 2: with mask=0xF, rise irq_src[3] and irq_src[1] in the same cycle -> irq_id=1 served first; after EOI -> irq_id=3 requested next cycle.
REQ-038 Scenario 3: with mask=0x0, pulse irq_src[0] -> pending=0x1 and ExtIRQ=0; then write mask=0x1 -> ExtIRQ=1 within 2 cycles.
REQ-039 Scenario 4: in SERVICE (id=0), pulse irq_src[0] -> pending[0]=1, ExtIRQ=0 until EOI, then re-request of id=0.
REQ-040 Scenario 5: in REQ (id=1), write mask=0x0 -> IDLE with pending[1]=1; same write plus ExtIAck in one cycle -> SERVICE with pending[1]=0.
REQ-041 Scenario 6: assert reset during SERVICE with irq_src[2] held high -> all outputs 0 and no pending after reset release.
